lsu_mem_ctrl: RTL and testbench

//  Load/store unit sitting directly downstream of the ALU: takes alu_data as effective address,

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_load_align.sv | 29 ++
 rtl/lsu_mem_ctrl.sv | 142 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// lane helpers (byte enables, store-data replication, alignment check).
// Pure package, no timing; imported by lsu_mem_ctrl and lsu_load_align.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } lsu_state_e;

  // Store byte enables; any funct3 that is not byte/half is a full word.
  function automatic logic [3:0] f_bmask(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_B, F3_BU: f_bmask = 4'b0001 << off;
      F3_H, F3_HU: f_bmask = 4'b0011 << off;
      default:     f_bmask = 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the byte enables alone pick the slot.
  function automatic logic [31:0] f_wdata(input logic [2:0] funct3, input logic [31:0] dat);
    case (funct3)
      F3_B, F3_BU: f_wdata = {4{dat[7:0]}};
      F3_H, F3_HU: f_wdata = {2{dat[15:0]}};
      default:     f_wdata = dat;
    endcase
  endfunction

  // 1 when the access is naturally aligned for its width.
  function automatic logic f_align_chk(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: f_align_chk = 1'b1;
      F3_H, F3_HU: f_align_chk = (addr_lo[0] == 1'b0);
      default:     f_align_chk = (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: selects byte/half/word from the read word and extends it.
// Latency: purely combinational. Backpressure: none.
// Ports: rdata_i read word, funct3_i access type, off_i byte offset, ld_data_o result.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  output logic [31:0] ld_data_o
);

  // Bring the addressed byte/half down to bit 0; only the low 16 bits matter.
  logic [15:0] sh;
  assign sh = 16'(rdata_i >> {off_i, 3'b000});

  always_comb begin
    ld_data_o = rdata_i;
    case (funct3_i)
      F3_B:    ld_data_o = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   ld_data_o = {24'h0, sh[7:0]};
      F3_H:    ld_data_o = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   ld_data_o = {16'h0, sh};
      F3_W:    ld_data_o = rdata_i;
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns the ALU effective address into a byte/half/word
// access on a req/ack memory port and returns aligned, extended load data.
// Latency: 3 cycles request-to-retire minimum (+1 per ack wait cycle).
// Backpressure: lsu_stall holds the core while the access is in flight.
// Ports: clk/rst (sync, active-high); lsu_req/lsu_we/lsu_funct3/alu_data/rs2_data
// from the core; lsu_stall/lsu_done/ld_data/misalign/bus_err back to it;
// mem_req/mem_we/mem_addr/mem_bmask/mem_wdata/mem_ack/mem_rdata to data memory.
// Build option: define LSU_TIMEOUT_EN to add the ack-wait timeout (bus_err).
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] alu_data,
  input  logic [31:0] rs2_data,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] ld_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_bmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [29:0] addr_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [3:0]  bmask_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        mem_we_q;

  logic        aligned;
  logic        accept;
  logic        tmo;        // give up waiting this cycle
  logic        err_resp;   // the response being presented is a timeout
  logic [31:0] align_dat;

  assign aligned = f_align_chk(lsu_funct3, alu_data[1:0]);
  assign accept  = !rst && (state_q == S_IDLE) && lsu_req && aligned;

`ifdef LSU_TIMEOUT_EN
  logic [7:0] wait_q;
  logic       berr_q;

  assign tmo      = (state_q == S_ACCESS) && !mem_ack && (wait_q == 8'(TIMEOUT_CYC - 1));
  assign err_resp = (state_q == S_RESP) && berr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= 8'h0;
      berr_q <= 1'b0;
    end else begin
      if (accept) begin
        wait_q <= 8'h0;
      end else if (state_q == S_ACCESS) begin
        wait_q <= wait_q + 8'd1;
      end
      // Rewritten every ACCESS cycle; the value on the exit cycle is what RESP reports.
      if (state_q == S_ACCESS) begin
        berr_q <= tmo;
      end
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign tmo      = 1'b0;
  assign err_resp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_ACCESS;
      S_ACCESS: if (mem_ack || tmo) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;  // lsu_req here is the retiring instruction
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= 30'h0;
      off_q    <= 2'b00;
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      bmask_q  <= 4'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      mem_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= alu_data[31:2];
        off_q    <= alu_data[1:0];
        we_q     <= lsu_we;
        f3_q     <= lsu_funct3;
        mem_we_q <= lsu_we;
        bmask_q  <= lsu_we ? f_bmask(lsu_funct3, alu_data[1:0]) : 4'hF;
        wdata_q  <= lsu_we ? f_wdata(lsu_funct3, rs2_data) : 32'h0;
      end else if ((state_q == S_ACCESS) && (state_d == S_RESP)) begin
        mem_we_q <= 1'b0;  // write strobe only while the request is up
      end
      if ((state_q == S_ACCESS) && mem_ack) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  lsu_load_align u_load_align (
    .rdata_i   (rdata_q),
    .funct3_i  (f3_q),
    .off_i     (off_q),
    .ld_data_o (align_dat)
  );

  assign lsu_stall = accept || (!rst && (state_q == S_ACCESS));
  assign misalign  = !rst && (state_q == S_IDLE) && lsu_req && !aligned;
  assign lsu_done  = (state_q == S_RESP);
  assign bus_err   = err_resp;
  assign ld_data   = ((state_q == S_RESP) && !we_q && !err_resp) ? align_dat : 32'h0;
  assign mem_req   = (state_q == S_ACCESS);
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_bmask = bmask_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: byte-addressed reference memory, request and
// response scoreboards, a memory responder with random ack delays/spurious acks.
module tb_lsu_mem_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req, lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] alu_data, rs2_data;
  logic        lsu_stall, lsu_done, misalign, bus_err;
  logic [31:0] ld_data;
  logic        mem_req, mem_we, mem_ack;
  logic [29:0] mem_addr;
  logic [3:0]  mem_bmask;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .alu_data(alu_data), .rs2_data(rs2_data), .lsu_stall(lsu_stall), .lsu_done(lsu_done),
    .ld_data(ld_data), .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_bmask(mem_bmask), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct { bit mis; bit berr; logic [31:0] ld; int stalls; } resp_t;
  typedef struct { logic [29:0] waddr; bit we; logic [3:0] bmask; logic [31:0] wdata; int dly; } req_t;

  resp_t       resp_q[$];
  req_t        req_q[$];
  logic [7:0]  ref_mem [64];   // reference view, byte addressed
  logic [31:0] dmem [16];      // what the responder serves, word addressed
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic int width_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
    dmem[addr[5:2]] = val;
    for (int b = 0; b < 4; b++) ref_mem[int'(addr[5:2]) * 4 + b] = val[8*b +: 8];
  endtask

  task automatic idle(input int n);
    lsu_req    = 1'b0;
    lsu_we     = 1'($urandom);
    lsu_funct3 = 3'($urandom);
    alu_data   = $urandom;
    rs2_data   = $urandom;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction retires.
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] d, input int dly);
    resp_t r;
    req_t  q;
    int w, base, off, t;
    bit tmo;
    logic [31:0] v;
    w    = width_of(f3);
    base = int'(addr[5:0]);
    off  = int'(addr[1:0]);
    tmo  = 1'b0;
`ifdef LSU_TIMEOUT_EN
    tmo  = (dly >= TMO);
`endif
    r.mis = (off % w) != 0;
    r.berr = 1'b0;
    r.ld = 32'h0;
    r.stalls = 0;
    if (!r.mis) begin
      q.waddr = addr[31:2];
      q.we    = we;
      q.dly   = dly;
      q.bmask = we ? 4'h0 : 4'hF;
      q.wdata = 32'h0;
      if (we) begin
        for (int i = 0; i < w; i++) q.bmask[off + i] = 1'b1;
        for (int k = 0; k < 4; k++) q.wdata[8*k +: 8] = d[8*(k % w) +: 8];
      end
      req_q.push_back(q);
      if (tmo) begin
        r.berr = 1'b1;
        r.stalls = 1 + TMO;
      end else begin
        r.stalls = 2 + dly;
        if (we) begin
          for (int i = 0; i < w; i++) ref_mem[base + i] = d[8*i +: 8];
        end else begin
          v = 32'h0;
          for (int i = 0; i < w; i++) v[8*i +: 8] = ref_mem[base + i];
          if (w < 4 && !f3[2] && v[8*w - 1])
            for (int i = w; i < 4; i++) v[8*i +: 8] = 8'hFF;
          r.ld = v;
        end
      end
    end
    resp_q.push_back(r);
    lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; alu_data = addr; rs2_data = d;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(lsu_done || misalign) && t < 100);
    if (!(lsu_done || misalign)) flag("response_timeout");
    @(posedge clk);
    #1;
  endtask

  // Memory responder: checks each new request against the request scoreboard.
  initial begin : mem_model
    bit   active;
    int   cnt;
    req_t q;
    active = 1'b0; cnt = 0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (rst) begin
        active = 1'b0;
      end else if (mem_req) begin
        if (!active) begin
          active = 1'b1;
          cnt = 0;
          if (req_q.size() == 0) begin
            flag("unexpected_mem_req");
          end else begin
            q = req_q.pop_front();
            cnt = q.dly;
            chk("mem_addr", 32'(mem_addr), 32'(q.waddr));
            chk("mem_we", 32'(mem_we), 32'(q.we));
            chk("mem_bmask", 32'(mem_bmask), 32'(q.bmask));
            if (q.we) chk("mem_wdata", mem_wdata, q.wdata);
          end
        end
        if (cnt == 0) begin
          mem_ack = 1'b1;
          mem_rdata = dmem[mem_addr[3:0]];
          if (mem_we)
            for (int k = 0; k < 4; k++)
              if (mem_bmask[k]) dmem[mem_addr[3:0]][8*k +: 8] = mem_wdata[8*k +: 8];
          active = 1'b0;
        end else begin
          cnt--;
        end
      end else begin
        active = 1'b0;
        mem_ack = ($urandom_range(0, 3) == 0);  // stray ack outside an access
      end
    end
  end

  // Response monitor: counts stall cycles and checks every retire/reject.
  initial begin : monitor
    int    stall_cnt;
    resp_t r;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
      end else begin
        if (lsu_stall) stall_cnt++;
        if (lsu_done || misalign) begin
          if (resp_q.size() == 0) begin
            flag("unexpected_response");
          end else begin
            r = resp_q.pop_front();
            chk("misalign", 32'(misalign), 32'(r.mis));
            chk("lsu_done", 32'(lsu_done), 32'(!r.mis));
            chk("stall_cycles", 32'(stall_cnt), 32'(r.stalls));
            chk("ld_data", ld_data, r.ld);
            chk("bus_err", 32'(bus_err), 32'(r.berr));
          end
          stall_cnt = 0;
        end
      end
    end
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_lsu_done"}, 32'(lsu_done), 32'h0);
    chk({tag, "_misalign"}, 32'(misalign), 32'h0);
    chk({tag, "_bus_err"}, 32'(bus_err), 32'h0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_mem_bmask"}, 32'(mem_bmask), 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_ld_data"}, ld_data, 32'h0);
    chk({tag, "_lsu_stall"}, 32'(lsu_stall), 32'h0);
  endtask

  initial begin : stim
    req_t  rq;
    logic [2:0] f3;
    rst = 1'b1;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b000; alu_data = 32'h0; rs2_data = 32'h0;
    for (int i = 0; i < 16; i++) set_word(32'(i * 4), $urandom);
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases
    set_word(32'h100, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 0);           // LW, ack first ACCESS cycle
    set_word(32'h100, 32'h80FF_0000);
    issue(1'b0, 3'b000, 32'h103, 32'h0, 1);           // LB  -> FFFFFF80
    issue(1'b0, 3'b100, 32'h103, 32'h0, 0);           // LBU -> 00000080
    issue(1'b0, 3'b101, 32'h102, 32'h0, 2);           // LHU -> 000080FF
    idle(1);
    issue(1'b1, 3'b000, 32'h201, 32'h12345678, 0);    // SB lane 1
    issue(1'b0, 3'b010, 32'h102, 32'h0, 0);           // LW misaligned
    issue(1'b0, 3'b001, 32'h201, 32'h0, 0);           // LH misaligned
    issue(1'b0, 3'b001, 32'h100, 32'h0, 3);           // LH reads back stored byte

    // Reset in the third ACCESS cycle of a slow load
    idle(2);
    rq.waddr = 30'h41; rq.we = 1'b0; rq.bmask = 4'hF; rq.wdata = 32'h0; rq.dly = 5;
    req_q.push_back(rq);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; alu_data = 32'h104;
    repeat (3) @(posedge clk);
    #1;
    chk("mem_req_before_rst", 32'(mem_req), 32'h1);
    rst = 1'b1;
    lsu_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_quiet("rst_mid_access");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

`ifdef LSU_TIMEOUT_EN
    set_word(32'h110, 32'hCAFEF00D);
    issue(1'b0, 3'b010, 32'h110, 32'h0, 50);          // times out
    issue(1'b1, 3'b010, 32'h110, 32'h11111111, 50);   // dropped store
    issue(1'b0, 3'b010, 32'h110, 32'h0, 0);           // original word still there
`endif

    // Random traffic, mixed widths/alignments, back-to-back or spaced
    for (int n = 0; n < 300; n++) begin
      f3 = 3'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), f3, 32'h100 + 32'($urandom_range(0, 63)),
            $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(5);
    chk("req_q_left", 32'(req_q.size()), 32'h0);
    chk("resp_q_left", 32'(resp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
